// File: rtl/gpia_wb_ctrl_if.sv
// Wishbone B4 classic 16-bit bus bundle between the CPU interconnect and gpia_wb_ctrl.
// Signal names keep the slave-side _i/_o suffixes so the wiring reads like the slave's port list.
interface gpia_wb_ctrl_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  adr_i;
  logic [1:0]  sel_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/gpia_wb_ctrl.sv
// Wishbone 16-bit slave that sequences hword accesses into a 64-bit GPIA_DWORD bank:
// IDLE -> EXEC (one-cycle byte strobes) -> WAIT (WAIT_STATES cycles) -> ACK.
module gpia_wb_ctrl #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          clk_i,
  input  logic          res_i,
  gpia_wb_ctrl_if.slave wb,
  output logic [1:0]    gpia_mode_o,
  output logic [63:0]   gpia_d_o,
  output logic [7:0]    gpia_stb_o,
  input  logic [63:0]   gpia_q_i
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [1:0]  lane_q;
  logic [15:0] lane_data;

  assign lane_data = gpia_q_i[{lane_q, 4'b0000} +: 16];

  // NOTE: every register here is updated with <= so all of them see the pre-edge values;
  // a blocking assignment would let later statements observe the new state in the same edge.
  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      lane_q      <= '0;
      wb.ack_o    <= 1'b0;
      wb.dat_o    <= '0;
      gpia_stb_o  <= '0;
      gpia_mode_o <= '0;
      gpia_d_o    <= '0;
    end else begin
      // Pulse outputs default low; only the entering transition raises them for one cycle.
      gpia_stb_o <= '0;
      wb.ack_o   <= 1'b0;
      wb.dat_o   <= '0;

      case (state)
        S_IDLE: begin
          if (wb.cyc_i && wb.stb_i) begin
            we_q   <= wb.we_i;
            lane_q <= wb.adr_i[1:0];
            state  <= S_EXEC;
            // Strobes, data and mode are registered on entry so they are valid throughout EXEC.
            if (wb.we_i) begin
              gpia_stb_o  <= {6'b000000, wb.sel_i} << {wb.adr_i[1:0], 1'b0};
              gpia_d_o    <= {4{wb.dat_i}};
              gpia_mode_o <= wb.adr_i[3:2];
            end
          end
        end

        S_EXEC: begin
          if (!wb.cyc_i) begin
            state <= S_IDLE;
          end else if (WAIT_STATES > 0) begin
            state    <= S_WAIT;
            wait_cnt <= WS_LAST;
          end else begin
            state    <= S_ACK;
            wb.ack_o <= 1'b1;
            wb.dat_o <= we_q ? 16'h0000 : lane_data;
          end
        end

        S_WAIT: begin
          if (!wb.cyc_i) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state    <= S_ACK;
            wb.ack_o <= 1'b1;
            wb.dat_o <= we_q ? 16'h0000 : lane_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_ACK: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gpia_wb_ctrl.md
Name: gpia_wb_ctrl

Overview:
Wishbone B4 classic 16-bit slave that sequences accesses into a 64-bit GPIA_DWORD register bank.
- Maps each 16-bit bus write onto one hword lane of the dword by generating per-byte GPIA strobes, replicated data and the GPIA mode.
- Returns the addressed hword of the GPIA output on reads.
- Sits between the CPU-side Wishbone interconnect and GPIA_DWORD in the Kestrel I/O subsystem.

Parameters:
WAIT_STATES, 1, extra cycles (0..15) between the GPIA execute cycle and ack_o; gives slow fabric or pins settle time.

Ports:
clk_i  in  1  system clock; all logic on rising edge
res_i  in  1  reset, synchronous, active-low
cyc_i  in  1  Wishbone cycle valid
stb_i  in  1  Wishbone strobe
we_i  in  1  1 = write, 0 = read
adr_i  in  4  [1:0] hword lane (0..3); [3:2] GPIA mode
sel_i  in  2  byte selects within hword; [0] = low byte
dat_i  in  16  write data
dat_o  out  16  read data; valid only while ack_o = 1
ack_o  out  1  Wishbone acknowledge
gpia_mode_o  out  2  to GPIA_DWORD mode_i
gpia_d_o  out  64  to GPIA_DWORD d_i
gpia_stb_o  out  8  to GPIA_DWORD stb_i (one bit per byte)
gpia_q_i  in  64  from GPIA_DWORD q_o

Behaviour:
- Reset (res_i = 0 at a rising edge):
  - FSM goes to IDLE and the wait counter clears.
  - ack_o, dat_o, gpia_stb_o, gpia_mode_o and gpia_d_o all go to 0.
  - Reset overrides every other condition, including mid-transaction; no ack is issued for an interrupted transaction.
- FSM states: IDLE, EXEC, WAIT, ACK.
- IDLE:
  - If cyc_i & stb_i are high at an edge, latch we_i, adr_i, sel_i and dat_i, then go to EXEC.
  - Otherwise remain in IDLE.
- EXEC (exactly 1 cycle):
  - Writes: gpia_stb_o[2L] = sel[0] and gpia_stb_o[2L+1] = sel[1], where L = latched lane. All other strobe bits are 0.
  - Writes: gpia_d_o = {4{dat}} and gpia_mode_o = adr[3:2]. GPIA_DWORD latches the values at the edge that ends EXEC.
  - Reads: gpia_stb_o = 0.
  - Next state is WAIT if WAIT_STATES > 0, otherwise ACK.
- WAIT:
  - The counter runs for WAIT_STATES cycles, then the FSM goes to ACK.
- ACK (exactly 1 cycle):
  - ack_o = 1, then return to IDLE.
  - For reads, dat_o is registered from gpia_q_i[16L+15:16L] at the edge entering ACK.
  - For writes, dat_o = 0.
- Strobe pulse: gpia_stb_o is high only during EXEC and is 0 in all other states.
- Data and mode hold: gpia_d_o and gpia_mode_o hold their last written values outside EXEC.
- Latency, with N = the edge that samples the request in IDLE:
  - ack_o is high during the cycle following edge N+1+WAIT_STATES.
  - With WAIT_STATES = 1, ack_o is high in the 3rd cycle after the request is sampled.
- Back-to-back transactions:
  - A new request is accepted only in IDLE, so there is at least one idle cycle between acks.
  - A master that keeps stb_i high after ack is served again from IDLE.
- Abort: if cyc_i = 0 at any edge while in EXEC or WAIT, return to IDLE with no ack.
  - A strobe already issued in EXEC is not undone.
  - Abort with stb_i dropped while cyc_i stays high is not supported; the transaction completes.
- Empty write (sel = 00): no strobe bit is set, but the full handshake and ack still occur.
- Reads ignore sel_i.
- Requests arriving while not in IDLE are not sampled.

Test Plan:
1. Hold res_i = 0 for 2 edges with random bus inputs -> ack_o = 0, dat_o = 0, gpia_stb_o = 0, gpia_d_o = 0, gpia_mode_o = 0; the first request after release is served normally.
2. WAIT_STATES = 1; write adr = 4'b0010, sel = 11, dat = 16'h3C3C -> gpia_stb_o = 8'b00110000 for exactly one cycle; gpia_d_o = 64'h3C3C3C3C3C3C3C3C; gpia_mode_o = 0; ack_o high one cycle, 3 cycles after the sampling edge.
3. Write adr = 4'b1111, sel = 10, dat = 16'hA500 -> gpia_stb_o = 8'b10000000 and gpia_mode_o = 2'b11 for one cycle. Then write with sel = 00 -> gpia_stb_o stays 0 and ack_o still pulses.
4. gpia_q_i = 64'h0123456789ABCDEF; read lane 1, then lane 3 -> dat_o = 16'h89AB, then 16'h0123, each with a one-cycle ack_o; gpia_stb_o stays 0 throughout.
5. WAIT_STATES = 3; start a write, drop cyc_i in the 2nd WAIT cycle -> no ack_o, FSM in IDLE, one strobe pulse seen. A following read completes with correct data.
6. Assert res_i = 0 on the edge ending EXEC of a write -> gpia_stb_o = 0 and gpia_d_o = 0 after that edge, no ack_o; the FSM accepts a request 1 cycle after release.
